// File: rtl/opl3_pkg.sv
// Shared types and constants for the codec bring-up sequencer.
package opl3_pkg;

  // 7-bit I2C address of the audio codec
  localparam logic [6:0] CODEC_I2C_ADDR = 7'h1A;

  // One codec register write, sent over I2C as {reg_addr, data}.
  // The address field is named reg_addr because "reg" is a keyword.
  typedef struct packed {
    logic [6:0] reg_addr;
    logic [8:0] data;
  } codec_write_t;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_POWER_WAIT,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_GAP,
    ST_ACT_WAIT,
    ST_DONE,
    ST_ERROR
  } codec_cfg_state_t;

  // Larger of two integers, for sizing shared counters
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Default codec init table: step index -> register write.
// The final entry is always the "active" write (reg 0x09 = 0x001),
// whatever the table length, so the codec is enabled last.
module codec_init_rom
  import opl3_pkg::*;
#(
  parameter int NUM_WRITES = 10,
  parameter int STEP_W     = 4
) (
  input  logic [STEP_W-1:0] step_i,
  output codec_write_t      entry_o
);

  localparam logic [STEP_W-1:0] LAST_STEP    = STEP_W'(NUM_WRITES - 1);
  localparam codec_write_t      ACTIVE_WRITE = '{reg_addr: 7'h09, data: 9'h001};

  // Table lookup; entries beyond the default list read as zero
  always_comb begin
    entry_o = '0;
    if (step_i == LAST_STEP) begin
      entry_o = ACTIVE_WRITE;
    end else begin
      case (int'(step_i))
        0: entry_o = '{reg_addr: 7'h0F, data: 9'h000}; // software reset
        1: entry_o = '{reg_addr: 7'h06, data: 9'h000}; // power up all blocks
        2: entry_o = '{reg_addr: 7'h00, data: 9'h017}; // left line-in volume
        3: entry_o = '{reg_addr: 7'h01, data: 9'h017}; // right line-in volume
        4: entry_o = '{reg_addr: 7'h02, data: 9'h079}; // left headphone volume
        5: entry_o = '{reg_addr: 7'h03, data: 9'h079}; // right headphone volume
        6: entry_o = '{reg_addr: 7'h04, data: 9'h012}; // analog path: DAC select
        7: entry_o = '{reg_addr: 7'h05, data: 9'h000}; // digital path: unmute
        8: entry_o = '{reg_addr: 7'h07, data: 9'h002}; // I2S, 16-bit
        default: entry_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/codec_config_sequencer.sv
// Codec bring-up sequencer: waits for power-up, writes the init table
// through the I2C master with retry on NACK/timeout, waits for VMID
// settling before the final "active" write, then enables I2S.
module codec_config_sequencer
  import opl3_pkg::*;
#(
  parameter int  NUM_WRITES          = 10,
  parameter int  POWERUP_CYCLES      = 2_000_000,
  parameter int  INTER_WRITE_CYCLES  = 1000,
  parameter int  ACTIVATE_CYCLES     = 5_000_000,
  parameter int  RESP_TIMEOUT_CYCLES = 100_000,
  parameter int  MAX_RETRIES         = 3,
  localparam int STEP_W  = width_of(NUM_WRITES),
  localparam int CNT_W   = width_of(max_int(max_int(POWERUP_CYCLES, INTER_WRITE_CYCLES),
                                            max_int(ACTIVATE_CYCLES, RESP_TIMEOUT_CYCLES))),
  localparam int RETRY_W = width_of(MAX_RETRIES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [6:0]        cmd_dev_addr,
  output logic [15:0]       cmd_data,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  output logic              i2s_enable,
  output logic              config_done,
  output logic              config_error,
  output logic [STEP_W-1:0] step
);

  // Counter reload values: a load of N-1 counts N cycles down to zero
  localparam logic [CNT_W-1:0]   POWERUP_LOAD = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LOAD     = CNT_W'(INTER_WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   ACT_LOAD     = CNT_W'(ACTIVATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LOAD = CNT_W'(RESP_TIMEOUT_CYCLES - 1);
  localparam logic [STEP_W-1:0]  LAST_STEP    = STEP_W'(NUM_WRITES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  codec_cfg_state_t   state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RETRY_W-1:0] retries_q;
  logic               act_done_q;   // VMID settling wait already spent this pass
  logic [STEP_W-1:0]  step_q;
  logic               cmd_valid_q;
  logic [15:0]        cmd_data_q;
  logic               i2s_enable_q;
  logic               config_done_q;
  logic               config_error_q;

  codec_write_t rom_entry;
  logic         cnt_zero;
  logic         last_step;

  assign cnt_zero  = (cnt_q == '0);
  assign last_step = (step_q == LAST_STEP);

  codec_init_rom #(
    .NUM_WRITES (NUM_WRITES),
    .STEP_W     (STEP_W)
  ) u_rom (
    .step_i  (step_q),
    .entry_o (rom_entry)
  );

  // Main sequencer FSM; every output is a register updated here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_POWER_WAIT;
      cnt_q          <= POWERUP_LOAD;
      retries_q      <= '0;
      act_done_q     <= 1'b0;
      step_q         <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_data_q     <= '0;
      i2s_enable_q   <= 1'b0;
      config_done_q  <= 1'b0;
      config_error_q <= 1'b0;
    end else begin
      case (state_q)
        // Both delays end the same way: the settling wait is inserted once
        // before the last entry, otherwise the write is issued directly.
        ST_POWER_WAIT, ST_GAP: begin
          if (cnt_zero) begin
            if (last_step && !act_done_q) begin
              state_q    <= ST_ACT_WAIT;
              cnt_q      <= ACT_LOAD;
              act_done_q <= 1'b1;
            end else begin
              state_q     <= ST_ISSUE;
              cmd_valid_q <= 1'b1;
              cmd_data_q  <= rom_entry;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_ACT_WAIT: begin
          if (cnt_zero) begin
            state_q     <= ST_ISSUE;
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= rom_entry;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        // Hold the command until the I2C master takes it; the response
        // timeout only starts once the command has been accepted.
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            cnt_q       <= TIMEOUT_LOAD;
            state_q     <= ST_WAIT_RESP;
          end
        end

        // A response on the expiry cycle wins over the timeout
        ST_WAIT_RESP: begin
          if (rsp_valid && !rsp_nack) begin
            retries_q <= '0;
            if (last_step) begin
              state_q       <= ST_DONE;
              config_done_q <= 1'b1;
              i2s_enable_q  <= 1'b1;
            end else begin
              step_q  <= step_q + STEP_W'(1);
              state_q <= ST_GAP;
              cnt_q   <= GAP_LOAD;
            end
          end else if (rsp_valid || cnt_zero) begin
            if (retries_q == RETRY_MAX) begin
              state_q        <= ST_ERROR;
              config_error_q <= 1'b1;
              i2s_enable_q   <= 1'b0;
            end else begin
              retries_q <= retries_q + RETRY_W'(1);
              state_q   <= ST_GAP;
              cnt_q     <= GAP_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        // Terminal states; only a restart pulse leaves them
        ST_DONE, ST_ERROR: begin
          if (restart) begin
            state_q        <= ST_POWER_WAIT;
            cnt_q          <= POWERUP_LOAD;
            retries_q      <= '0;
            act_done_q     <= 1'b0;
            step_q         <= '0;
            i2s_enable_q   <= 1'b0;
            config_done_q  <= 1'b0;
            config_error_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_POWER_WAIT;
          cnt_q   <= POWERUP_LOAD;
        end
      endcase
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_data     = cmd_data_q;
  assign cmd_dev_addr = CODEC_I2C_ADDR;
  assign i2s_enable   = i2s_enable_q;
  assign config_done  = config_done_q;
  assign config_error = config_error_q;
  assign step         = step_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with short delay parameters.
module tb_codec_config_sequencer;

  localparam int NW   = 10;
  localparam int PU   = 16;
  localparam int GAPC = 4;
  localparam int ACT  = 32;
  localparam int TMO  = 64;
  localparam int RETR = 3;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic        restart   = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic        rsp_nack  = 1'b0;
  logic        cmd_valid;
  logic [6:0]  cmd_dev_addr;
  logic [15:0] cmd_data;
  logic        i2s_enable;
  logic        config_done;
  logic        config_error;
  logic [3:0]  step;

  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   ref_cyc = 0;
  int   t_seen  = 0;
  logic pre_err = 1'b0;

  // Expected command words {reg[6:0], data[8:0]}
  logic [15:0] exp_tab [NW] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
                                16'h0679, 16'h0812, 16'h0A00, 16'h0E02, 16'h1201};

  codec_config_sequencer #(
    .NUM_WRITES          (NW),
    .POWERUP_CYCLES      (PU),
    .INTER_WRITE_CYCLES  (GAPC),
    .ACTIVATE_CYCLES     (ACT),
    .RESP_TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES         (RETR)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .restart      (restart),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dev_addr (cmd_dev_addr),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_nack     (rsp_nack),
    .i2s_enable   (i2s_enable),
    .config_done  (config_done),
    .config_error (config_error),
    .step         (step)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected cycles from the previous reference point to cmd_valid
  function automatic int exp_wait(input int i);
    if (i == 0) return PU;
    if (i == NW - 1) return GAPC + ACT;
    return GAPC;
  endfunction

  task automatic wait_valid(output int t);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("cmd_valid_seen", 32'(cmd_valid), 32'd1);
    t = cyc;
  endtask

  // One write transaction. mode 0: respond (ACK/NACK) resp_dly cycles after
  // accept; mode 1: never respond, return at the timeout edge; mode 2:
  // return right after the command is accepted.
  task automatic run_write(input int idx, input int wait_exp, input int ready_dly,
                           input int resp_dly, input logic nack, input int mode);
    int   t;
    logic stable;
    logic quiet;
    wait_valid(t);
    chk($sformatf("w%0d_delay", idx), 32'(t - ref_cyc), 32'(wait_exp));
    chk($sformatf("w%0d_data", idx), 32'(cmd_data), 32'(exp_tab[idx]));
    chk($sformatf("w%0d_step", idx), 32'(step), 32'(idx));
    stable = 1'b1;
    for (int k = 0; k < ready_dly; k++) begin
      tick();
      if (cmd_valid !== 1'b1 || cmd_data !== exp_tab[idx]) stable = 1'b0;
    end
    chk($sformatf("w%0d_hold", idx), 32'(stable), 32'd1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk($sformatf("w%0d_accept_drop", idx), 32'(cmd_valid), 32'd0);
    chk($sformatf("w%0d_done_early", idx), 32'(config_done), 32'd0);
    if (mode == 0) begin
      quiet = 1'b1;
      for (int k = 0; k < resp_dly; k++) begin
        tick();
        if (cmd_valid !== 1'b0) quiet = 1'b0;
      end
      chk($sformatf("w%0d_single_cmd", idx), 32'(quiet), 32'd1);
      rsp_valid = 1'b1;
      rsp_nack  = nack;
      tick();
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      ref_cyc   = cyc;
    end else if (mode == 1) begin
      repeat (TMO - 1) tick();
      pre_err = config_error;
      tick();
      ref_cyc = cyc;
    end
  endtask

  initial begin
    // Reset state
    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_data", 32'(cmd_data), 32'd0);
    chk("rst_i2s_enable", 32'(i2s_enable), 32'd0);
    chk("rst_config_done", 32'(config_done), 32'd0);
    chk("rst_config_error", 32'(config_error), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("dev_addr", 32'(cmd_dev_addr), 32'h1A);
    reset_n = 1'b1;
    ref_cyc = cyc;

    // Pass A: plain bring-up; a restart pulse mid-sequence must be ignored
    for (int i = 0; i < NW; i++) begin
      run_write(i, exp_wait(i), 2, 0, 1'b0, 0);
      if (i == 4) begin
        restart = 1'b1;
        tick();
        restart = 1'b0;
      end
    end
    chk("A_done", 32'(config_done), 32'd1);
    chk("A_i2s", 32'(i2s_enable), 32'd1);
    chk("A_error", 32'(config_error), 32'd0);
    chk("A_step", 32'(step), 32'd9);
    repeat (5) tick();
    chk("A_done_hold", 32'(config_done), 32'd1);
    chk("A_no_cmd", 32'(cmd_valid), 32'd0);

    // Pass B: restart from DONE; stalled cmd_ready on write 3, NACKs on write 5
    restart = 1'b1;
    tick();
    restart = 1'b0;
    ref_cyc = cyc;
    chk("B_restart_done", 32'(config_done), 32'd0);
    chk("B_restart_i2s", 32'(i2s_enable), 32'd0);
    chk("B_restart_step", 32'(step), 32'd0);
    for (int i = 0; i < NW; i++) begin
      if (i == 3) begin
        run_write(3, GAPC, 50, 40, 1'b0, 0);
      end else if (i == 5) begin
        run_write(5, GAPC, 2, 0, 1'b1, 0);
        run_write(5, GAPC, 2, 0, 1'b1, 0);
        run_write(5, GAPC, 2, 0, 1'b0, 0);
      end else begin
        run_write(i, exp_wait(i), 2, 0, 1'b0, 0);
      end
    end
    chk("B_done", 32'(config_done), 32'd1);
    chk("B_error", 32'(config_error), 32'd0);
    chk("B_i2s", 32'(i2s_enable), 32'd1);

    // Pass C: write 2 never answered -> four timed-out attempts, then ERROR
    restart = 1'b1;
    tick();
    restart = 1'b0;
    ref_cyc = cyc;
    run_write(0, PU, 2, 0, 1'b0, 0);
    run_write(1, GAPC, 2, 0, 1'b0, 0);
    for (int a = 0; a < RETR + 1; a++) run_write(2, GAPC, 2, 0, 1'b0, 1);
    chk("C_err_not_early", 32'(pre_err), 32'd0);
    chk("C_error", 32'(config_error), 32'd1);
    chk("C_step", 32'(step), 32'd2);
    chk("C_i2s", 32'(i2s_enable), 32'd0);
    chk("C_done", 32'(config_done), 32'd0);
    repeat (20) tick();
    chk("C_no_fifth_attempt", 32'(cmd_valid), 32'd0);
    chk("C_error_hold", 32'(config_error), 32'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    ref_cyc = cyc;
    chk("C_restart_error", 32'(config_error), 32'd0);
    chk("C_restart_step", 32'(step), 32'd0);

    // Pass D: rerun to write 7, then reset while waiting for its response
    for (int i = 0; i < 7; i++) run_write(i, exp_wait(i), 2, 0, 1'b0, 0);
    run_write(7, GAPC, 2, 0, 1'b0, 2);
    reset_n = 1'b0;
    #1;
    chk("D_rst_step", 32'(step), 32'd0);
    chk("D_rst_cmd_data", 32'(cmd_data), 32'd0);
    chk("D_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("D_rst_error", 32'(config_error), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    ref_cyc = cyc;
    // Spurious response during POWER_WAIT must not disturb timing
    tick();
    tick();
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    wait_valid(t_seen);
    chk("D_first_delay", 32'(t_seen - ref_cyc), 32'(PU));
    chk("D_first_data", 32'(cmd_data), 32'(exp_tab[0]));
    // Reset while a command is pending drops cmd_valid without a clock edge
    reset_n = 1'b0;
    #1;
    chk("D_rst_drops_valid", 32'(cmd_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    ref_cyc = cyc;

    // Pass E: full sequence after the reset
    for (int i = 0; i < NW; i++) run_write(i, exp_wait(i), 2, 0, 1'b0, 0);
    chk("E_done", 32'(config_done), 32'd1);
    chk("E_i2s", 32'(i2s_enable), 32'd1);
    chk("E_error", 32'(config_error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop so the run always ends
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
